// File: rtl/alu_issue.sv
// In-order ALU issue block: command FIFO, 8-entry register file and an IDLE/ISSUE/WB sequencer.
// Optional register debug read port is enabled by defining ALU_ISSUE_DBG_EN.
module alu_issue #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_opcode,
    input  logic [2:0]   cmd_rd,
    input  logic [2:0]   cmd_rs1,
    input  logic [2:0]   cmd_rs2,
    input  logic         ld_valid,
    input  logic [2:0]   ld_addr,
    input  logic [N-1:0] ld_data,
    output logic [2:0]   alu_opcode,
    output logic [N-1:0] alu_op_a,
    output logic [N-1:0] alu_op_b,
    input  logic [N-1:0] alu_result,
    output logic         wb_valid,
    output logic [2:0]   wb_addr,
    output logic [N-1:0] wb_data,
    output logic         busy
`ifdef ALU_ISSUE_DBG_EN
    ,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WB
    } state_t;

    cmd_t          r_fifo [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [2:0]    r_rd;
    logic [N-1:0]  r_rf [8];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    cmd_t w_head;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = !w_empty && (r_state != S_ISSUE);
    assign w_head    = r_fifo[r_rptr];
    assign cmd_ready = !w_full;
    assign busy      = (r_state != S_IDLE) || !w_empty;

`ifdef ALU_ISSUE_DBG_EN
    assign dbg_data = r_rf[dbg_addr];
`endif

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= '{cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            alu_opcode <= '0;
            alu_op_a   <= '0;
            alu_op_b   <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (ld_valid) r_rf[ld_addr] <= ld_data;
            // Writeback is assigned after the load so it wins a same-address collision.
            case (r_state)
                S_IDLE, S_WB: begin
                    if (!w_empty) begin
                        r_state    <= S_ISSUE;
                        r_rd       <= w_head.rd;
                        alu_opcode <= w_head.op;
                        alu_op_a   <= r_rf[w_head.rs1];
                        alu_op_b   <= r_rf[w_head.rs2];
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_rf[r_rd] <= alu_result;
                    wb_valid   <= 1'b1;
                    wb_addr    <= r_rd;
                    wb_data    <= alu_result;
                    r_state    <= S_WB;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
